// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the mod-13 counter sequencing controller.
//   seq_state_t : FSM state encoding (IDLE, LOAD, RUN, HOLD, DONE)
//   MOD_DEFAULT : default counter modulus
//   DIR_UP/DOWN : direction encoding shared by dir and cnt_updown
package counter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  localparam int   MOD_DEFAULT = 13;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_pass_counter.sv
// seq_pass_counter: PASS_W-bit pass counter for the sequencing controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (new run accepted)
//   inc        : count one terminal-count event
//   passes     : latched number of passes for the current run
//   cnt        : passes seen so far
//   last       : the next increment reaches passes (this event is the final one)
module seq_pass_counter #(
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [PASS_W-1:0] passes,
  output logic [PASS_W-1:0] cnt,
  output logic              last
);

  // Compare the incremented value so the FSM can leave RUN on the same
  // edge that counts the final pass.
  assign last = ((cnt + PASS_W'(1)) == passes);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + PASS_W'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run sequencer for a 4-bit mod-MOD up/down counter.
// Loads the counter once, lets it run through a requested number of
// terminal-count events, then pulses done.
// Optional feature macro: SEQ_HOLD_EN (compiles in the HOLD state; when
// undefined the hold port is accepted but ignored).
// Ports:
//   CLK, MR_n            : clock, asynchronous active-low reset
//   start, dir, preset,
//   passes               : run request and its parameters (sampled in IDLE)
//   abort                : end the current run immediately, no done pulse
//   hold                 : pause counting while in RUN
//   cnt_co               : counter terminal count
//   cnt_load_n, cnt_en,
//   cnt_updown, cnt_d    : counter control pins (registered)
//   busy, done, pass_cnt : status (registered)
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int MOD    = MOD_DEFAULT,
  parameter int PASS_W = 8
) (
  input  logic              CLK,
  input  logic              MR_n,
  input  logic              start,
  input  logic              dir,
  input  logic [3:0]        preset,
  input  logic [PASS_W-1:0] passes,
  input  logic              abort,
  input  logic              hold,
  input  logic              cnt_co,
  output logic              cnt_load_n,
  output logic              cnt_en,
  output logic              cnt_updown,
  output logic [3:0]        cnt_d,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  // Out-of-range load values saturate to the top legal count.
  function automatic logic [3:0] clamp_preset(input logic [3:0] p);
    if (int'(p) >= MOD) return 4'(MOD - 1);
    return p;
  endfunction

  seq_state_t        state, state_nxt;
  logic [PASS_W-1:0] passes_q;
  logic              accept;
  logic              pass_inc;
  logic              pass_last;

  assign accept   = (state == IDLE) && start;
  // abort wins over a coincident terminal count: that pass is not counted.
  assign pass_inc = (state == RUN) && cnt_co && !abort;

`ifndef SEQ_HOLD_EN
  logic hold_unused;
  assign hold_unused = hold;
`endif

  seq_pass_counter #(.PASS_W(PASS_W)) u_pass (
    .clk    (CLK),
    .rst_n  (MR_n),
    .clr    (accept),
    .inc    (pass_inc),
    .passes (passes_q),
    .cnt    (pass_cnt),
    .last   (pass_last)
  );

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort)                state_nxt = IDLE;
        else if (passes_q == '0)  state_nxt = DONE;
        else                      state_nxt = RUN;
      end
      RUN: begin
        if (abort)                   state_nxt = IDLE;
        else if (cnt_co && pass_last) state_nxt = DONE;
`ifdef SEQ_HOLD_EN
        // A terminal count together with hold is still counted above.
        else if (hold)               state_nxt = HOLD;
`endif
      end
`ifdef SEQ_HOLD_EN
      HOLD: begin
        if (abort)      state_nxt = IDLE;
        else if (!hold) state_nxt = RUN;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state so every
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state      <= IDLE;
      cnt_load_n <= 1'b1;
      cnt_en     <= 1'b0;
      cnt_updown <= DIR_UP;
      cnt_d      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      passes_q   <= '0;
    end else begin
      state      <= state_nxt;
      cnt_load_n <= (state_nxt != LOAD);
      cnt_en     <= (state_nxt == RUN);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      if (accept) begin
        cnt_d      <= clamp_preset(preset);
        cnt_updown <= dir;
        passes_q   <= passes;
      end
    end
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller for the 4-bit mod-13 up/down counter. It accepts a run command with preset, direction and pass count, then drives the counter's LOAD/EN/UpDown/D pins. It loads the counter once, lets it count through the requested number of terminal-count events, and reports completion. The controller sits between the control logic and the counter instance, which keeps ownership of Q and CO.

## Interface
Parameters:
- MOD, 13: counter modulus. Legal values are 0..MOD-1.
- PASS_W, 8: width of the pass count and pass counter.

Ports:
- CLK  in  1  system clock, rising edge.
- MR_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE only.
- dir  in  1  0 = count up, 1 = count down.
- preset  in  4  counter load value; values ≥ MOD are clamped to MOD-1.
- passes  in  PASS_W  number of terminal-count events to run.
- abort  in  1  stops the current run at once.
- hold  in  1  pauses counting (see Configuration).
- cnt_co  in  1  counter carry/borrow (terminal count) output.
- cnt_load_n  out  1  counter synchronous load, active-low.
- cnt_en  out  1  counter enable.
- cnt_updown  out  1  counter direction, same encoding as dir.
- cnt_d  out  4  counter parallel load data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- pass_cnt  out  PASS_W  terminal-count events seen in the current or last run.

## Operation
- Moore FSM with states IDLE, LOAD, RUN, HOLD, DONE. All outputs are registered.
- IDLE:
  - Outputs: cnt_en=0, cnt_load_n=1.
  - On start: latch dir, clamped preset and passes; clear pass_cnt; go to LOAD.
- LOAD:
  - Outputs: cnt_load_n=0, cnt_en=0, cnt_d=latched preset, cnt_updown=latched dir.
  - Next state: DONE if passes==0, else RUN.
- RUN:
  - Outputs: cnt_en=1, cnt_load_n=1.
  - On each edge with cnt_co=1: increment pass_cnt.
  - If the incremented value equals passes, go to DONE.
- HOLD: cnt_en=0. Return to RUN when hold drops. cnt_co is ignored while in HOLD.
- DONE: done=1, cnt_en=0. Go to IDLE on the next edge.
- abort=1 in LOAD/RUN/HOLD/DONE: go to IDLE next edge, with no done pulse. pass_cnt keeps its value.
- Priority within one cycle: abort > terminal count > hold.
  - abort and cnt_co together: the pass is not counted.
  - cnt_co and hold together: the pass is counted and the transition to DONE is taken; otherwise go to HOLD.
- start while busy is ignored. Latched parameters stay stable for the whole run.
- pass_cnt holds its final value until the next accepted start.

## Timing
- Reset values: state=IDLE, cnt_load_n=1, cnt_en=0, cnt_updown=0, cnt_d=0, busy=0, done=0, pass_cnt=0.
- Reset is asynchronous at any point, including mid-run. Outputs return to reset values immediately.
- start sampled at edge k:
  - LOAD during cycle k+1, so the counter loads at edge k+2.
  - cnt_en is high from cycle k+2.
- Final cnt_co sampled at edge m: done=1 and cnt_en=0 during cycle m+1; busy=0 from cycle m+2.
- With cnt_co asserted during every RUN cycle, passes=N gives N RUN cycles. Minimum start-to-done is N+2 cycles.
- passes=0: LOAD then DONE, so done is high in cycle k+2 and cnt_en is never asserted.

## Configuration
- SEQ_HOLD_EN defined:
  - HOLD state and hold logic are compiled in.
  - hold=1 in RUN moves to HOLD at the next edge.
- SEQ_HOLD_EN undefined:
  - The hold port remains but is ignored.
  - HOLD state is not compiled; RUN never pauses.

## Structure
- counter_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, HOLD, DONE);
  - localparam MOD_DEFAULT=13;
  - direction constants DIR_UP=0, DIR_DOWN=1.
- Sub-module seq_pass_counter: PASS_W-bit clear/increment counter with an equality compare against the latched passes. It produces the last-pass flag used by the FSM.

## Test plan
- Reset, then start with preset=4'b1100, dir=0, passes=2, cnt_co modelled by a mod-13 counter:
  - cnt_load_n=0 for one cycle with cnt_d=12;
  - done pulses exactly once after the second CO;
  - pass_cnt=2, cnt_en=0 afterwards.
- Start with preset=15, dir=1, passes=1 → cnt_d=12 (clamped), cnt_updown=1, done after the first borrow.
- passes=0 → LOAD then DONE, cnt_en never high, done in cycle k+2.
- abort raised in RUN, in the same cycle as cnt_co → next cycle IDLE, no done, pass_cnt not incremented.
- With SEQ_HOLD_EN: hold high for 5 cycles during RUN → cnt_en=0 for those cycles, pass_cnt frozen, run resumes. Without SEQ_HOLD_EN: hold has no effect.
- MR_n pulsed low mid-RUN → all outputs at reset values immediately. A start after release runs normally; a start issued while busy is ignored.
